// File: rtl/scr1_ahb_sram_resp_pkg.sv
// Shared AHB-Lite definitions for the SRAM responder: bus width, htrans and
// hsize encodings, and the responder FSM state type.
package scr1_ahb_sram_resp_pkg;

  localparam int unsigned SCR1_AHB_WIDTH = 32;

  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SCR1_HSIZE_8BIT  = 3'd0;
  localparam logic [2:0] SCR1_HSIZE_16BIT = 3'd1;
  localparam logic [2:0] SCR1_HSIZE_32BIT = 3'd2;

  typedef enum logic [1:0] {
    SCR1_AHB_RESP_IDLE = 2'd0,
    SCR1_AHB_RESP_DATA = 2'd1,
    SCR1_AHB_RESP_ERR1 = 2'd2,
    SCR1_AHB_RESP_ERR2 = 2'd3
  } type_scr1_ahb_resp_state_e;

endpackage

// File: rtl/scr1_ahb_sram_bemask.sv
// Byte-enable decoder for little-endian AHB writes.
//   i_hsize   : captured transfer size
//   i_addr_lo : captured haddr[1:0]
//   o_be      : one bit per byte lane of the 32-bit word (0 for unsupported sizes)
module scr1_ahb_sram_bemask
  import scr1_ahb_sram_resp_pkg::*;
(
  input  logic [2:0] i_hsize,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_be
);

  always_comb begin
    o_be = '0;
    case (i_hsize)
      SCR1_HSIZE_8BIT:  o_be = 4'b0001 << i_addr_lo;
      SCR1_HSIZE_16BIT: o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      SCR1_HSIZE_32BIT: o_be = '1;
      default:          o_be = '0;
    endcase
  end

endmodule

// File: rtl/scr1_ahb_sram_resp.sv
// AHB-Lite responder in front of a byte-addressable SRAM (2^N bytes).
// Wait states come from a rotating stall pattern (bit=1 means ready), illegal
// transfers get a two-cycle ERROR, and a backdoor port allows full-word preload.
//   clk, rst_n         : clock, asynchronous active-low reset
//   stall_pattern_in   : pattern loaded on stall_load pulse
//   hsize/htrans/haddr/hwrite/hwdata : AHB request
//   hready/hrdata/hresp: AHB response
//   bd_we/bd_addr/bd_wdata/bd_ack    : backdoor word write, ack is combinational
module scr1_ahb_sram_resp
  import scr1_ahb_sram_resp_pkg::*;
#(
  parameter int unsigned SCR1_MEM_POWER_SIZE = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SCR1_AHB_WIDTH-1:0]      stall_pattern_in,
  input  logic                           stall_load,
  input  logic [2:0]                     hsize,
  input  logic [1:0]                     htrans,
  input  logic [SCR1_AHB_WIDTH-1:0]      haddr,
  input  logic                           hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0]      hwdata,
  output logic                           hready,
  output logic [SCR1_AHB_WIDTH-1:0]      hrdata,
  output logic                           hresp,
  input  logic                           bd_we,
  input  logic [SCR1_MEM_POWER_SIZE-3:0] bd_addr,
  input  logic [SCR1_AHB_WIDTH-1:0]      bd_wdata,
  output logic                           bd_ack
);

  localparam int unsigned N     = SCR1_MEM_POWER_SIZE;
  localparam int unsigned WORDS = 2 ** (N - 2);

  type_scr1_ahb_resp_state_e r_state;
  type_scr1_ahb_resp_state_e w_next_sel;
  logic [SCR1_AHB_WIDTH-1:0] r_pat;
  logic [N-1:0]              r_haddr;
  logic [2:0]                r_hsize;
  logic                      r_hwrite;
  logic [SCR1_AHB_WIDTH-1:0] r_mem [WORDS];

  logic       w_accept;
  logic       w_illegal;
  logic       w_wr_complete;
  logic [3:0] w_be;
  logic [N-3:0] w_widx;

  assign w_widx   = r_haddr[N-1:2];
  assign w_accept = hready & ((htrans == SCR1_HTRANS_NONSEQ) | (htrans == SCR1_HTRANS_SEQ));

  always_comb begin
    w_illegal = 1'b0;
    if (hsize > SCR1_HSIZE_32BIT)                        w_illegal = 1'b1;
    if ((hsize == SCR1_HSIZE_16BIT) && haddr[0])         w_illegal = 1'b1;
    if ((hsize == SCR1_HSIZE_32BIT) && (haddr[1:0] != '0)) w_illegal = 1'b1;
    if (haddr[SCR1_AHB_WIDTH-1:N] != '0)                 w_illegal = 1'b1;
  end

  // Where the bus goes whenever the current cycle ends with hready=1.
  always_comb begin
    w_next_sel = SCR1_AHB_RESP_IDLE;
    if (w_accept) w_next_sel = w_illegal ? SCR1_AHB_RESP_ERR1 : SCR1_AHB_RESP_DATA;
  end

  // Response decoded from registered state and pattern only.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    case (r_state)
      SCR1_AHB_RESP_DATA: hready = r_pat[0];
      SCR1_AHB_RESP_ERR1: begin hready = 1'b0; hresp = 1'b1; end
      SCR1_AHB_RESP_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  assign w_wr_complete = (r_state == SCR1_AHB_RESP_DATA) & r_pat[0] & r_hwrite;
  assign bd_ack        = bd_we & ~w_wr_complete;
  assign hrdata        = ((r_state == SCR1_AHB_RESP_DATA) && !r_hwrite) ? r_mem[w_widx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SCR1_AHB_RESP_IDLE;
      r_pat    <= '1;
      r_haddr  <= '0;
      r_hsize  <= '0;
      r_hwrite <= 1'b0;
    end else begin
      if (stall_load)
        r_pat <= stall_pattern_in;
      else if (r_state == SCR1_AHB_RESP_DATA)
        r_pat <= {r_pat[0], r_pat[SCR1_AHB_WIDTH-1:1]};

      case (r_state)
        SCR1_AHB_RESP_ERR1: r_state <= SCR1_AHB_RESP_ERR2;
        SCR1_AHB_RESP_DATA: if (r_pat[0]) r_state <= w_next_sel;
        default:            r_state <= w_next_sel;
      endcase

      if (w_accept) begin
        r_haddr  <= haddr[N-1:0];
        r_hsize  <= hsize;
        r_hwrite <= hwrite;
      end
    end
  end

  scr1_ahb_sram_bemask u_bemask (
    .i_hsize   (r_hsize),
    .i_addr_lo (r_haddr[1:0]),
    .o_be      (w_be)
  );

  // Array is not reset; the AHB write has priority over the backdoor.
  always_ff @(posedge clk) begin
    if (w_wr_complete) begin
      for (int unsigned i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= hwdata[8*i +: 8];
    end else if (bd_ack) begin
      r_mem[bd_addr] <= bd_wdata;
    end
  end

endmodule

// File: tb/tb_scr1_ahb_sram_resp.sv
module tb_scr1_ahb_sram_resp;
  import scr1_ahb_sram_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] stall_pattern_in;
  logic        stall_load;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;
  logic        bd_we;
  logic [13:0] bd_addr;
  logic [31:0] bd_wdata;
  logic        bd_ack;

  always #5 clk = ~clk;

  scr1_ahb_sram_resp #(.SCR1_MEM_POWER_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_pattern_in(stall_pattern_in), .stall_load(stall_load),
    .hsize(hsize), .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata), .hresp(hresp),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_ack(bd_ack)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       xq[$];
  logic [7:0]  bmem [512];   // byte-level model of the low 512 bytes
  logic [31:0] pat_val;
  int unsigned pat_idx;      // how many DATA cycles the pattern has rotated
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_illegal(xfer_t x);
    return (x.size > 3'd2) || (x.size == 3'd1 && x.addr % 2 != 0) ||
           (x.size == 3'd2 && x.addr % 4 != 0) || (x.addr >= 32'h1_0000);
  endfunction

  function automatic int unsigned zeros_ahead();
    int unsigned k = 0;
    while (pat_val[(pat_idx + k) % 32] == 1'b0 && k < 32) k++;
    return k;
  endfunction

  function automatic logic [31:0] model_word(logic [31:0] a);
    int unsigned w = (int'(a) / 4) * 4;
    return {bmem[w+3], bmem[w+2], bmem[w+1], bmem[w]};
  endfunction

  task automatic model_write(xfer_t x);
    for (int b = 0; b < (1 << x.size); b++) begin
      int unsigned a = int'(x.addr) + b;
      bmem[a] = x.wdata[8*(a%4) +: 8];
    end
  endtask

  task automatic model_bd(int unsigned idx, logic [31:0] d);
    for (int b = 0; b < 4; b++) bmem[idx*4 + b] = d[8*b +: 8];
  endtask

  task automatic drive_addr(xfer_t x);
    haddr  = x.addr;
    hsize  = x.size;
    hwrite = x.wr;
    htrans = ($urandom_range(0, 3) == 0) ? SCR1_HTRANS_SEQ : SCR1_HTRANS_NONSEQ;
  endtask

  task automatic push(logic [31:0] a, logic [2:0] s, logic w, logic [31:0] d);
    xfer_t x;
    x.addr = a; x.size = s; x.wr = w; x.wdata = d;
    xq.push_back(x);
  endtask

  task automatic load_pat(logic [31:0] p);
    stall_pattern_in = p;
    stall_load = 1'b1;
    @(posedge clk); #1;
    stall_load = 1'b0;
    pat_val = p;
    pat_idx = 0;
  endtask

  task automatic bd_write(int unsigned idx, logic [31:0] d);
    bd_we = 1'b1; bd_addr = 14'(idx); bd_wdata = d;
    @(negedge clk);
    chk("bd_ack_free", 32'(bd_ack), 32'd1);
    @(posedge clk); #1;
    bd_we = 1'b0;
    model_bd(idx, d);
  endtask

  // IDLE/BUSY with an address that would be illegal if wrongly accepted.
  task automatic non_xfer_cycles(int unsigned n, logic [1:0] t);
    htrans = t; haddr = 32'h0001_0001; hsize = 3'd2;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk("ignore_rdy", 32'(hready), 32'd1);
      chk("ignore_resp", 32'(hresp), 32'd0);
      @(posedge clk); #1;
    end
    htrans = SCR1_HTRANS_IDLE;
  endtask

  // Pipelined initiator: issues the queued transfers back to back.
  task automatic run_queue();
    xfer_t cur, nxt;
    bit have_cur = 0, have_nxt = 0, done, rdy, rsp, cur_ill = 0;
    logic [31:0] rd;
    int unsigned cyc = 0, waits = 0, exp_waits = 0, budget = 0;
    if (xq.size() > 0) begin nxt = xq.pop_front(); have_nxt = 1; drive_addr(nxt); end
    while ((have_cur || have_nxt) && budget < 20000) begin
      budget++;
      @(negedge clk);
      rdy = hready; rsp = hresp; rd = hrdata; done = 0;
      if (have_cur) begin
        cyc++;
        if (cur_ill) begin
          if (cyc == 1) begin
            chk("err1_rdy", 32'(rdy), 32'd0); chk("err1_resp", 32'(rsp), 32'd1);
          end else begin
            chk("err2_rdy", 32'(rdy), 32'd1); chk("err2_resp", 32'(rsp), 32'd1);
            done = 1;
          end
          chk("err_rdata", rd, 32'd0);
        end else begin
          chk("okay_resp", 32'(rsp), 32'd0);
          if (rdy) begin
            chk("wait_states", waits, exp_waits);
            if (cur.wr) model_write(cur);
            else chk("rdata", rd, model_word(cur.addr));
            done = 1;
          end else waits++;
        end
      end else begin
        chk("idle_rdy", 32'(rdy), 32'd1);
        chk("idle_resp", 32'(rsp), 32'd0);
      end
      @(posedge clk); #1;
      if (done) have_cur = 0;
      if (rdy && have_nxt) begin
        cur = nxt; have_cur = 1; cyc = 0; waits = 0;
        cur_ill = is_illegal(cur);
        if (!cur_ill) begin
          exp_waits = zeros_ahead();
          pat_idx = (pat_idx + exp_waits + 1) % 32;
        end
        hwdata = cur.wdata;
        if (xq.size() > 0) begin nxt = xq.pop_front(); drive_addr(nxt); end
        else begin have_nxt = 0; htrans = SCR1_HTRANS_IDLE; end
      end
    end
    htrans = SCR1_HTRANS_IDLE;
    chk("queue_drained", 32'(have_cur | have_nxt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall_pattern_in = '0; stall_load = 1'b0;
    hsize = '0; htrans = SCR1_HTRANS_IDLE; haddr = '0; hwrite = 1'b0; hwdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    pat_val = '1; pat_idx = 0;
    #22;
    chk("reset_hready", 32'(hready), 32'd1);
    chk("reset_hresp", 32'(hresp), 32'd0);
    chk("reset_hrdata", hrdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 128; i++) bd_write(i, $urandom);

    // zero-wait write then back-to-back read of the same word
    load_pat(32'hFFFF_FFFF);
    push(32'h100, 3'd2, 1'b1, 32'hDEAD_BEEF);
    push(32'h100, 3'd2, 1'b0, $urandom);
    run_queue();

    // one wait per transfer with ...1010; second read sees the rotated pattern
    load_pat(32'hFFFF_FFFA);
    push(32'h100, 3'd2, 1'b0, 32'h0);
    push(32'h104, 3'd2, 1'b0, 32'h0);
    run_queue();

    // byte write into a preloaded word, then illegal halfword write
    load_pat(32'hFFFF_FFFF);
    bd_write(32'h40, 32'h1122_3344);
    push(32'h103, 3'd0, 1'b1, 32'h5A5A_5A5A);
    push(32'h100, 3'd2, 1'b0, 32'h0);
    push(32'h101, 3'd1, 1'b1, 32'hFFFF_FFFF);
    push(32'h100, 3'd2, 1'b0, 32'h0);
    run_queue();
    chk("byte_merge_model", model_word(32'h100), 32'h5A22_3344);

    // out-of-range read, then a NONSEQ accepted in ERR2
    push(32'h1_0000, 3'd2, 1'b0, 32'h0);
    push(32'h104, 3'd2, 1'b0, 32'h0);
    run_queue();

    non_xfer_cycles(2, SCR1_HTRANS_BUSY);
    non_xfer_cycles(2, SCR1_HTRANS_IDLE);

    // backdoor collides with AHB write to word 5 and is dropped
    load_pat(32'hFFFF_FFFF);
    haddr = 32'h14; hsize = 3'd2; hwrite = 1'b1; htrans = SCR1_HTRANS_NONSEQ;
    @(posedge clk); #1;
    htrans = SCR1_HTRANS_IDLE; hwdata = 32'hA5A5_0001;
    bd_we = 1'b1; bd_addr = 14'd5; bd_wdata = 32'h0BD0_0001;
    @(negedge clk);
    chk("bd_ack_conflict", 32'(bd_ack), 32'd0);
    @(posedge clk); #1;
    bd_we = 1'b0;
    model_bd(5, 32'hA5A5_0001); pat_idx = (pat_idx + 1) % 32;
    push(32'h14, 3'd2, 1'b0, 32'h0);
    run_queue();

    // same collision with the request held one more cycle
    haddr = 32'h14; hsize = 3'd2; hwrite = 1'b1; htrans = SCR1_HTRANS_NONSEQ;
    @(posedge clk); #1;
    htrans = SCR1_HTRANS_IDLE; hwdata = 32'hA5A5_0002;
    bd_we = 1'b1; bd_addr = 14'd5; bd_wdata = 32'h0BD0_0002;
    @(negedge clk);
    chk("bd_ack_conflict2", 32'(bd_ack), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bd_ack_held", 32'(bd_ack), 32'd1);
    @(posedge clk); #1;
    bd_we = 1'b0;
    model_bd(5, 32'h0BD0_0002); pat_idx = (pat_idx + 1) % 32;
    push(32'h14, 3'd2, 1'b0, 32'h0);
    run_queue();

    // randomized traffic under random patterns
    for (int r = 0; r < 12; r++) begin
      logic [31:0] p;
      p = $urandom | $urandom;
      if (p == 32'h0) p = 32'h1;
      load_pat(p);
      for (int t = 0; t < 20; t++) begin
        logic [31:0] a;
        logic [2:0]  s;
        int unsigned sel;
        sel = $urandom_range(0, 15);
        s = (sel == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a = (sel == 1) ? ($urandom | 32'h0001_0000) : 32'($urandom_range(0, 511));
        if (sel > 4) a = a & ~((32'd1 << s) - 32'd1);
        push(a, s, 1'($urandom_range(0, 1)), $urandom);
      end
      run_queue();
    end

    // reset during a stalled write aborts it
    load_pat(32'hFFFF_FFFE);
    haddr = 32'h20; hsize = 3'd2; hwrite = 1'b1; htrans = SCR1_HTRANS_NONSEQ;
    @(posedge clk); #1;
    htrans = SCR1_HTRANS_IDLE; hwdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("stall_before_rst", 32'(hready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_hready", 32'(hready), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    pat_val = '1; pat_idx = 0;
    push(32'h20, 3'd2, 1'b0, 32'h0);
    run_queue();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scr1_ahb_sram_resp.md
# scr1_ahb_sram_resp

AHB-Lite responder (slave) fronting a byte-addressable SRAM array, built as the counterpart to the core's imem/dmem AHB initiator ports. It is synthesizable and runs in one clock domain. It inserts wait states from a programmable rotating stall pattern, returns two-cycle ERROR responses for illegal transfers, and provides a backdoor write port for program preload. The bench instantiates one per port, and FPGA bring-up instantiates one as on-chip RAM.

## Interface
- `SCR1_MEM_POWER_SIZE`, default 16: memory size is 2^N bytes; word count is 2^(N-2).
- `SCR1_AHB_WIDTH`, from `scr1_ahb.svh` (32): data and address width.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `stall_pattern_in` input, 32: wait-state pattern. Bit value 1 means ready.
- `stall_load` input, 1: one-cycle pulse that loads `stall_pattern_in` into the pattern register.
- `hsize` input, 3: AHB transfer size.
- `htrans` input, 2: AHB transfer type.
- `haddr` input, 32: AHB address.
- `hwrite` input, 1: AHB write/read select.
- `hwdata` input, 32: write data, sampled in the data phase.
- `hready` output, 1: transfer-done / address-phase accept.
- `hrdata` output, 32: read data.
- `hresp` output, 1: 0 = OKAY, 1 = ERROR.
- `bd_we` input, 1: backdoor write request.
- `bd_addr` input, N-2: backdoor word index.
- `bd_wdata` input, 32: backdoor full-word data.
- `bd_ack` output, 1: combinational; the backdoor write is accepted this cycle.

## Operation
- An address phase is accepted when `hready`=1 and `htrans` is NONSEQ (2'b10) or SEQ (2'b11).
- IDLE (2'b00) and BUSY (2'b01) are ignored and get a zero-wait OKAY.
- On accept, the block registers `haddr`, `hsize` and `hwrite`, and classifies the transfer as illegal if any of the following hold:
  - `hsize` > 2;
  - `hsize`=1 and `haddr[0]`=1;
  - `hsize`=2 and `haddr[1:0]`≠0;
  - `haddr` ≥ 2^N.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE: `hready`=1, `hresp`=0. On a legal accept go to DATA; on an illegal accept go to ERR1.
  - DATA: `hready` = `pat_q[0]`.
    - While `hready`=0, stay in DATA and hold the captured phase.
    - When `hready`=1 the transfer completes. A new accept in the same cycle goes to DATA or ERR1 as classified; with no new accept, go to IDLE.
  - ERR1: `hready`=0, `hresp`=1. Always go to ERR2.
  - ERR2: `hready`=1, `hresp`=1. Any address phase presented here is accepted normally, or the initiator may drive IDLE. Next state is chosen as in IDLE.
- Stall pattern register `pat_q`:
  - Rotates right by 1 every cycle while in DATA.
  - Holds in all other states.
  - `stall_load` overrides the rotate in the same cycle.
- Write completion updates only the byte lanes selected by `haddr_q[1:0]` and `hsize_q` (little-endian), using `hwdata` from the completing cycle. The memory is updated at that clock edge.
- Read data: in DATA with `hwrite_q`=0, `hrdata` = the full word at `haddr_q[N-1:2]`; the initiator selects lanes. In all other states `hrdata` = 0.
- Backdoor: `bd_ack` = `bd_we` & ~(an AHB write completing this cycle). An acknowledged backdoor write updates the full word at the same edge. An unacknowledged request has no effect; the requester holds `bd_we`.
- Memory array contents are not reset.

## Timing
- Reset values: `hready`=1, `hresp`=0, `hrdata`=0, FSM=IDLE, `pat_q`=32'hFFFF_FFFF.
- Reset asserted mid-transfer aborts it. No memory write occurs on the aborting edge.
- Zero-wait transfer: accept at edge k, data phase completes in cycle k+1, giving single-cycle throughput for back-to-back NONSEQ.
- Each 0 bit consumed from `pat_q[0]` adds one wait cycle.
- A pattern of all zeros stalls forever. This is legal and the bench is responsible for avoiding it.
- Read-after-write to the same word is back-to-back with no hazard: the write lands at the completion edge, and the read data phase starts in the following cycle.
- An ERROR response always takes exactly two cycles, regardless of `pat_q`.
- `bd_ack` and `hrdata` are combinational outputs. `hready` and `hresp` are decoded from registered state and `pat_q` only; there is no input-to-output path.

## Structure
- `scr1_ahb.svh` gains:
  - `htrans` constants: IDLE, BUSY, NONSEQ, SEQ.
  - `hsize` constants: BYTE, HALF, WORD.
  - `type_scr1_ahb_resp_state_e`, the 2-bit FSM enum.
- Sub-module `scr1_ahb_sram_bemask`: combinational; maps `hsize` and `haddr[1:0]` to a 4-bit byte-enable.
- The array is an inferred `logic [31:0] mem[2**(N-2)]` with a byte-enabled write.

## Test plan
- Pattern FFFF_FFFF: write word 0xDEADBEEF to 0x100, then read 0x100 back-to-back → read returns 0xDEADBEEF in the cycle after the write, zero waits.
- Pattern FFFF_FFFA (…1010): single read → `hready` low for 1 cycle, then high. The next transfer sees the pattern rotated.
- Byte write 0x5A to 0x103 over word 0x11223344 → word reads back 0x5A223344. A halfword write to 0x101 → ERROR, response `hready`/`hresp` = 0/1, then 1/1, and memory unchanged.
- Read at 2^N (N=16, address 0x10000) → two-cycle ERROR. A NONSEQ presented in ERR2 is accepted and completes OKAY.
- Backdoor write to word 5 in the same cycle as an AHB write completing to word 5 → `bd_ack`=0, AHB data kept. `bd_we` held one more cycle → `bd_ack`=1, backdoor data kept.
- Reset asserted during a stalled write → outputs return to 1/0/0 immediately and the target word is unchanged.
